// File: rtl/car_motion.sv
`default_nettype none
// ============================================================================
// Module      : car_motion
// Description : Turns the direction stage's go/dir request into paced car
//               sprite moves. A frame-tick counter sets the step rate. Each
//               step runs erase -> update -> redraw against the VGA drawer
//               through a req/done handshake. The committed heading is fed
//               back to the direction stage as current_dir.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock       in   system clock, rising edge
//   resetn      in   asynchronous active-low reset
//   frame_tick  in   one-cycle pulse per video frame
//   go[1:0]     in   00/01 stop, 11 forward, 10 backward
//   dir[2:0]    in   requested heading (0=N, counter-clockwise to 7=NE)
//   draw_done   in   drawer completion (pulse or level)
//   x[X_W-1:0]  out  current car x
//   y[Y_W-1:0]  out  current car y
//   current_dir out  committed heading
//   erase_req   out  erase sprite at x,y
//   draw_req    out  draw sprite at x,y with current_dir
//   busy        out  high whenever the sequencer is not idle
//   hit_wall    out  one-cycle pulse when an axis was clamped
//   step_done   out  one-cycle pulse when a step has been redrawn
// ============================================================================
module car_motion #(
  parameter int X_W             = 8,
  parameter int Y_W             = 7,
  parameter int X_MAX           = 159,
  parameter int Y_MAX           = 119,
  parameter int X_INIT          = 80,
  parameter int Y_INIT          = 60,
  parameter int STEP            = 1,
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           frame_tick,
  input  logic [1:0]     go,
  input  logic [2:0]     dir,
  input  logic           draw_done,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [2:0]     current_dir,
  output logic           erase_req,
  output logic           draw_req,
  output logic           busy,
  output logic           hit_wall,
  output logic           step_done
);

  localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  localparam logic [CNT_W-1:0]      c_cnt_last = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [X_W-1:0]        c_x_init   = X_W'(X_INIT);
  localparam logic [Y_W-1:0]        c_y_init   = Y_W'(Y_INIT);
  localparam logic signed [X_W+1:0] c_x_max    = (X_W+2)'(X_MAX);
  localparam logic signed [Y_W+1:0] c_y_max    = (Y_W+2)'(Y_MAX);
  localparam logic signed [X_W+1:0] c_step_x   = (X_W+2)'(STEP);
  localparam logic signed [Y_W+1:0] c_step_y   = (Y_W+2)'(STEP);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ERASE  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DRAW   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_frame_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [X_W-1:0]        r_x;
  logic [Y_W-1:0]        r_y;
  logic [2:0]            r_dir;

  logic                  w_fwd;
  logic                  w_bwd;
  logic                  w_moving;
  logic signed [1:0]     w_hx;
  logic signed [1:0]     w_hy;
  logic signed [1:0]     w_dx;
  logic signed [1:0]     w_dy;
  logic signed [X_W+1:0] w_nx;
  logic signed [Y_W+1:0] w_ny;
  logic                  w_x_hit;
  logic                  w_y_hit;
  logic [X_W-1:0]        w_x_upd;
  logic [Y_W-1:0]        w_y_upd;
  logic                  w_upd_en;

  assign w_fwd    = (go == 2'b11);
  assign w_bwd    = (go == 2'b10);
  assign w_moving = w_fwd | w_bwd;

  // Heading unit vector; y grows downward so "north" is -1.
  always_comb begin
    w_hx = 2'sb00;
    w_hy = 2'sb00;
    case (dir)
      3'd0: begin w_hx = 2'sb00; w_hy = 2'sb11; end
      3'd1: begin w_hx = 2'sb11; w_hy = 2'sb11; end
      3'd2: begin w_hx = 2'sb11; w_hy = 2'sb00; end
      3'd3: begin w_hx = 2'sb11; w_hy = 2'sb01; end
      3'd4: begin w_hx = 2'sb00; w_hy = 2'sb01; end
      3'd5: begin w_hx = 2'sb01; w_hy = 2'sb01; end
      3'd6: begin w_hx = 2'sb01; w_hy = 2'sb00; end
      default: begin w_hx = 2'sb01; w_hy = 2'sb11; end
    endcase
  end

  // go is consumed directly in UPDATE; a stop seen there yields a zero move
  // while the heading is still committed and the sprite still redrawn.
  always_comb begin
    w_dx = 2'sb00;
    w_dy = 2'sb00;
    if (w_fwd) begin
      w_dx = w_hx;
      w_dy = w_hy;
    end else if (w_bwd) begin
      w_dx = -w_hx;
      w_dy = -w_hy;
    end
  end

  // Two guard bits so both underflow (sign bit) and overflow past MAX are
  // visible before truncation back to the coordinate width.
  assign w_nx = $signed({2'b00, r_x}) + $signed({{X_W{w_dx[1]}}, w_dx}) * c_step_x;
  assign w_ny = $signed({2'b00, r_y}) + $signed({{Y_W{w_dy[1]}}, w_dy}) * c_step_y;

  assign w_x_hit = w_nx[X_W+1] || (w_nx > c_x_max);
  assign w_y_hit = w_ny[Y_W+1] || (w_ny > c_y_max);

  assign w_x_upd = w_x_hit ? r_x : w_nx[X_W-1:0];
  assign w_y_upd = w_y_hit ? r_y : w_ny[Y_W-1:0];

  // Next-state, frame pacing and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_frame_cnt;
    erase_req   = 1'b0;
    draw_req    = 1'b0;
    hit_wall    = 1'b0;
    step_done   = 1'b0;
    w_upd_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_moving) begin
          w_cnt_nxt = '0;
        end else if (frame_tick) begin
          if (r_frame_cnt == c_cnt_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_ERASE;
          end else begin
            w_cnt_nxt = r_frame_cnt + CNT_W'(1);
          end
        end
      end
      ST_ERASE: begin
        erase_req = 1'b1;
        if (draw_done) begin
          w_state_nxt = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        w_upd_en    = 1'b1;
        hit_wall    = w_x_hit | w_y_hit;
        w_state_nxt = ST_DRAW;
      end
      ST_DRAW: begin
        draw_req = 1'b1;
        if (draw_done) begin
          step_done   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_frame_cnt <= '0;
      r_x         <= c_x_init;
      r_y         <= c_y_init;
      r_dir       <= 3'd0;
    end else begin
      r_frame_cnt <= w_cnt_nxt;
      if (w_upd_en) begin
        r_x   <= w_x_upd;
        r_y   <= w_y_upd;
        r_dir <= dir;
      end
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign current_dir = r_dir;
  assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire
